// File: rtl/cross_bar_pkg.sv
// Types shared by the crossbar demux buffers and the output-side mux arbiter.
package cross_bar_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int DEF_MSEL_WIDTH = 2;
  localparam int DEF_DATA_WIDTH = 32;

endpackage : cross_bar_pkg

// File: rtl/cross_bar_rr_arbiter.sv
// Combinational round-robin pick: first requester after i_rr_ptr, wrapping at CHANNEL_NO-1.
module cross_bar_rr_arbiter
  import cross_bar_pkg::*;
#(
  parameter int MSEL_WIDTH = DEF_MSEL_WIDTH,
  parameter int CHANNEL_NO = 2**MSEL_WIDTH
) (
  input  logic [CHANNEL_NO-1:0] i_req,
  input  logic [MSEL_WIDTH-1:0] i_rr_ptr,
  output logic [MSEL_WIDTH-1:0] o_winner,
  output logic                  o_any_req
);

  logic [MSEL_WIDTH-1:0] w_idx;

  // Scan farthest-first so the nearest requester after the pointer overwrites the others.
  always_comb begin
    o_winner  = '0;
    o_any_req = 1'b0;
    w_idx     = '0;
    for (int k = CHANNEL_NO; k >= 1; k--) begin
      w_idx = MSEL_WIDTH'((int'(i_rr_ptr) + k) % CHANNEL_NO);
      if (i_req[w_idx]) begin
        o_winner  = w_idx;
        o_any_req = 1'b1;
      end else begin
        o_any_req = o_any_req;
      end
    end
  end

endmodule : cross_bar_rr_arbiter

// File: rtl/cross_bar_mux_arbiter.sv
// Merges CHANNEL_NO AXI-Stream inputs into one output with packet-granular
// round-robin arbitration and a one-deep output register slice.
module cross_bar_mux_arbiter
  import cross_bar_pkg::*;
#(
  parameter int MSEL_WIDTH = DEF_MSEL_WIDTH,
  parameter int CHANNEL_NO = 2**MSEL_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata [CHANNEL_NO],
  input  logic [CHANNEL_NO-1:0] s_axis_tvalid,
  input  logic [CHANNEL_NO-1:0] s_axis_tlast,
  output logic [CHANNEL_NO-1:0] s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [MSEL_WIDTH-1:0] grant_bin,
  output logic                  busy
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [MSEL_WIDTH-1:0] r_grant_bin;
  logic [MSEL_WIDTH-1:0] r_rr_ptr;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_m_tvalid;
  logic                  r_m_tlast;

  logic [MSEL_WIDTH-1:0] w_winner;
  logic                  w_any_req;
  logic                  w_slice_room;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_load;
  logic [CHANNEL_NO-1:0] w_tready;

  cross_bar_rr_arbiter #(
    .MSEL_WIDTH(MSEL_WIDTH),
    .CHANNEL_NO(CHANNEL_NO)
  ) u_rr_arbiter (
    .i_req    (s_axis_tvalid),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_winner),
    .o_any_req(w_any_req)
  );

  // Only the granted channel may see ready, and only while the slice can take a beat.
  always_comb begin
    w_sel_valid  = s_axis_tvalid[r_grant_bin];
    w_sel_last   = s_axis_tlast[r_grant_bin];
    w_sel_data   = s_axis_tdata[r_grant_bin];
    w_slice_room = !r_m_tvalid || m_axis_tready;
    w_tready     = '0;
    if (r_state == ACTIVE) begin
      w_tready[r_grant_bin] = w_slice_room;
    end else begin
      w_tready = '0;
    end
    w_load = (r_state == ACTIVE) && w_sel_valid && w_slice_room;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ACTIVE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACTIVE: begin
        if (w_load && w_sel_last) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = ACTIVE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pointer resets to the last channel so channel 0 is first in line after reset.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_grant_bin <= '0;
      r_rr_ptr    <= MSEL_WIDTH'(CHANNEL_NO - 1);
    end else if ((r_state == IDLE) && w_any_req) begin
      r_grant_bin <= w_winner;
      r_rr_ptr    <= w_winner;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else if (w_load) begin
      r_m_tdata  <= w_sel_data;
      r_m_tlast  <= w_sel_last;
      r_m_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign s_axis_tready = w_tready;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign grant_bin     = r_grant_bin;
  assign busy          = (r_state == ACTIVE);

endmodule : cross_bar_mux_arbiter

// File: tb/tb_cross_bar_mux_arbiter.sv
// Directed bench for cross_bar_mux_arbiter: queued per-channel packet drivers,
// output beat capture and hand-written expected beat sequences.
module tb_cross_bar_mux_arbiter;

  localparam int MW = 2;
  localparam int CH = 4;
  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            gap;
  } beat_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic [DW-1:0] s_tdata [CH];
  logic [CH-1:0] s_axis_tvalid;
  logic [CH-1:0] s_axis_tlast;
  logic [CH-1:0] s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [MW-1:0] grant_bin;
  logic          busy;

  always #5 aclk = ~aclk;

  cross_bar_mux_arbiter #(
    .MSEL_WIDTH(MW),
    .CHANNEL_NO(CH),
    .DATA_WIDTH(DW)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .grant_bin    (grant_bin),
    .busy         (busy)
  );

  beat_t         chq [CH][$];
  logic [DW-1:0] out_d [$];
  logic          out_l [$];
  int            out_c [$];
  logic          out_b [$];
  logic [DW-1:0] exp_d [$];
  logic          exp_l [$];

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            t0;
  logic [3:0]    rdy_pat = 4'b1001;
  bit            rdy_pat_en;
  bit            own_en, own_act, victim_en;
  logic [MW-1:0] own_ch, victim_ch;
  bit            prev_stall;
  logic [DW-1:0] prev_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < CH; c++) begin
      if (chq[c].size() > 0 && chq[c][0].gap == 0) begin
        s_axis_tvalid[c] = 1'b1;
        s_axis_tlast[c]  = chq[c][0].last;
        s_tdata[c]       = chq[c][0].data;
      end else begin
        s_axis_tvalid[c] = 1'b0;
        s_axis_tlast[c]  = 1'b0;
        s_tdata[c]       = '0;
      end
    end
    m_axis_tready = rdy_pat_en ? rdy_pat[cyc % 4] : 1'b1;
  endtask

  task automatic push_pkt(input int c, input logic [DW-1:0] base, input int n,
                          input int gap_at, input int gap_len);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = base + DW'(i);
      b.last = (i == n - 1);
      b.gap  = (i == gap_at) ? gap_len : 0;
      chq[c].push_back(b);
    end
  endtask

  task automatic expect_pkt(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_d.push_back(base + DW'(i));
      exp_l.push_back(i == n - 1);
    end
  endtask

  // One clock: sample mid-cycle, run invariants, then advance drivers after the edge.
  task automatic tick();
    logic [CH-1:0] hs;
    beat_t         b;
    #4;
    hs = s_axis_tvalid & s_axis_tready;
    if (!busy) check_eq("idle_tready", 32'(s_axis_tready), 32'd0);
    if (prev_stall) begin
      check_eq("stall_valid", 32'(m_axis_tvalid), 32'd1);
      check_eq("stall_data", m_axis_tdata, prev_data);
    end
    if (busy && m_axis_tvalid && !m_axis_tready)
      check_eq("full_tready", 32'(s_axis_tready[grant_bin]), 32'd0);
    if (own_act) begin
      check_eq("own_busy", 32'(busy), 32'd1);
      check_eq("own_grant", 32'(grant_bin), 32'(own_ch));
      if (victim_en) check_eq("victim_tready", 32'(s_axis_tready[victim_ch]), 32'd0);
    end
    if (own_en && hs[own_ch]) begin
      own_act = 1'b1;
      if (s_axis_tlast[own_ch]) begin
        own_act = 1'b0;
        own_en  = 1'b0;
      end
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    if (m_axis_tvalid && m_axis_tready) begin
      out_d.push_back(m_axis_tdata);
      out_l.push_back(m_axis_tlast);
      out_c.push_back(cyc);
      out_b.push_back(busy);
    end
    @(posedge aclk);
    #1;
    cyc++;
    for (int c = 0; c < CH; c++) begin
      if (hs[c]) begin
        void'(chq[c].pop_front());
      end else if (chq[c].size() > 0 && chq[c][0].gap > 0) begin
        b = chq[c].pop_front();
        b.gap = b.gap - 1;
        chq[c].push_front(b);
      end
    end
    drive();
  endtask

  task automatic run_until(input int n, input int budget);
    int i = 0;
    while (out_d.size() < n && i < budget) begin
      tick();
      i++;
    end
    if (out_d.size() < n) check_eq("timeout", 32'(out_d.size()), 32'(n));
    repeat (4) tick();
  endtask

  task automatic check_out(input string tag);
    check_eq({tag, "_count"}, 32'(out_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < out_d.size(); i++) begin
      check_eq($sformatf("%s_d%0d", tag, i), out_d[i], exp_d[i]);
      check_eq($sformatf("%s_l%0d", tag, i), 32'(out_l[i]), 32'(exp_l[i]));
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    for (int c = 0; c < CH; c++) chq[c].delete();
    out_d.delete(); out_l.delete(); out_c.delete(); out_b.delete();
    exp_d.delete(); exp_l.delete();
    own_en = 1'b0; own_act = 1'b0; victim_en = 1'b0;
    prev_stall = 1'b0; rdy_pat_en = 1'b0;
    drive();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    #4;
    check_eq("rst_m_valid", 32'(m_axis_tvalid), 32'd0);
    check_eq("rst_m_data",  m_axis_tdata, 32'd0);
    check_eq("rst_m_last",  32'(m_axis_tlast), 32'd0);
    check_eq("rst_s_ready", 32'(s_axis_tready), 32'd0);
    check_eq("rst_busy",    32'(busy), 32'd0);
    check_eq("rst_grant",   32'(grant_bin), 32'd0);
    @(posedge aclk);
    #1;

    // T1: single 4-beat packet on channel 2
    push_pkt(2, 32'hA0, 4, -1, 0);
    own_en = 1'b1; own_ch = 2'd2;
    t0 = cyc;
    drive();
    run_until(4, 40);
    expect_pkt(32'hA0, 4);
    check_out("t1");
    if (out_c.size() >= 4) begin
      check_eq("t1_latency", 32'(out_c[0] - t0), 32'd2);
      check_eq("t1_consec",  32'(out_c[3] - out_c[0]), 32'd3);
      check_eq("t1_busy_b2", 32'(out_b[2]), 32'd1);
      check_eq("t1_busy_b3", 32'(out_b[3]), 32'd0);
    end

    // T2: all channels request 2-beat packets; channel 0 has a second one queued
    do_reset();
    push_pkt(0, 32'h000, 2, -1, 0);
    push_pkt(1, 32'h100, 2, -1, 0);
    push_pkt(2, 32'h200, 2, -1, 0);
    push_pkt(3, 32'h300, 2, -1, 0);
    push_pkt(0, 32'h010, 2, -1, 0);
    drive();
    run_until(10, 80);
    expect_pkt(32'h000, 2);
    expect_pkt(32'h100, 2);
    expect_pkt(32'h200, 2);
    expect_pkt(32'h300, 2);
    expect_pkt(32'h010, 2);
    check_out("t2");

    // T3: channel 3 requests while channel 1 is mid-packet
    do_reset();
    push_pkt(1, 32'h100, 4, -1, 0);
    own_en = 1'b1; own_ch = 2'd1; victim_en = 1'b1; victim_ch = 2'd3;
    drive();
    repeat (3) tick();
    push_pkt(3, 32'h300, 2, -1, 0);
    drive();
    run_until(6, 60);
    expect_pkt(32'h100, 4);
    expect_pkt(32'h300, 2);
    check_out("t3");

    // T4: downstream ready toggles 1,0,0,1 during a 5-beat packet
    do_reset();
    rdy_pat_en = 1'b1;
    push_pkt(0, 32'h000, 5, -1, 0);
    own_en = 1'b1; own_ch = 2'd0;
    drive();
    run_until(5, 60);
    expect_pkt(32'h000, 5);
    check_out("t4");

    // T5: channel 0 valid gap of 3 cycles mid-packet while channel 2 waits
    do_reset();
    push_pkt(0, 32'h000, 5, 2, 3);
    push_pkt(2, 32'h200, 2, -1, 0);
    own_en = 1'b1; own_ch = 2'd0; victim_en = 1'b1; victim_ch = 2'd2;
    drive();
    run_until(7, 60);
    expect_pkt(32'h000, 5);
    expect_pkt(32'h200, 2);
    check_out("t5");

    // T6: asynchronous reset between clock edges in the middle of a packet
    do_reset();
    push_pkt(1, 32'h100, 6, -1, 0);
    drive();
    repeat (4) tick();
    #2;
    check_eq("t6_pre_valid", 32'(m_axis_tvalid), 32'd1);
    areset = 1'b1;
    #1;
    check_eq("t6_rst_valid", 32'(m_axis_tvalid), 32'd0);
    check_eq("t6_rst_ready", 32'(s_axis_tready), 32'd0);
    check_eq("t6_rst_busy",  32'(busy), 32'd0);
    check_eq("t6_rst_data",  m_axis_tdata, 32'd0);
    do_reset();
    push_pkt(3, 32'h300, 1, -1, 0);
    push_pkt(0, 32'h000, 1, -1, 0);
    drive();
    run_until(2, 30);
    expect_pkt(32'h000, 1);
    expect_pkt(32'h300, 1);
    check_out("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cross_bar_mux_arbiter
